// File: rtl/bus_pkg.sv
// Shared constants and types for the two-master system bus arbiter.
// The state encoding is fixed so that debug probes can decode it directly.
package bus_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;
    localparam int NUM_MASTERS = 2;

    localparam int M_CPU = 0;
    localparam int M_DMA = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        ACK    = ST_ACK
    } state_t;

    function automatic logic [NUM_MASTERS-1:0] idx2oh(input logic idx);
        idx2oh = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner select with a sticky lock for the previous winner.
// Written for N masters so a third requester only needs a wider req/lock vector.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  lock,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic          found;
    logic [IW-1:0] cand;

    // Scan starts just after the last winner; i == N wraps back to last itself,
    // which covers the case where only the previous winner is requesting.
    always_comb begin
        valid  = |req;
        winner = last;
        found  = 1'b0;
        cand   = '0;
        if (req[last] && lock[last]) begin
            found = 1'b1;
        end
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter: round-robin with lock, fixed wait states per access,
// all bus and master-side outputs registered.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] addressBus,
    output logic              writeEnBus,
    output logic [DATA_W-1:0] data_c2r,
    input  logic [DATA_W-1:0] data_r2c
);

    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

    state_t                               state_q, state_d;
    logic [2:0]                           cnt_q, cnt_d;
    logic                                 last_q, last_d;
    logic [NUM_MASTERS-1:0]               gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0]               ack_q, ack_d;
    logic [NUM_MASTERS-1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]                    addr_q, addr_d;
    logic                                 we_q, we_d;
    logic [DATA_W-1:0]                    wd_q, wd_d;

    logic [NUM_MASTERS-1:0]               req_v, lock_v, we_v;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0]   addr_v;
    logic [NUM_MASTERS-1:0][DATA_W-1:0]   wd_v;
    logic                                 pick_w, pick_v, owner;

    assign req_v  = {m1_req, m0_req};
    assign lock_v = {m1_lock, m0_lock};
    assign we_v   = {m1_we, m0_we};
    assign addr_v = {m1_addr, m0_addr};
    assign wd_v   = {m1_wdata, m0_wdata};
    assign owner  = gnt_q[M_DMA];

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (1)
    ) u_pick (
        .req    (req_v),
        .lock   (lock_v),
        .last   (last_q),
        .winner (pick_w),
        .valid  (pick_v)
    );

    // The write strobe defaults low every cycle, so it survives only the grant edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (pick_v) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    last_d  = pick_w;
                    gnt_d   = idx2oh(pick_w);
                    addr_d  = addr_v[pick_w];
                    we_d    = we_v[pick_w];
                    wd_d    = wd_v[pick_w];
                end
            end
            ACCESS: begin
                if (cnt_q == WS_LAST) begin
                    state_d        = ACK;
                    ack_d[owner]   = 1'b1;
                    rdata_d[owner] = data_r2c;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                ack_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
        end
    end

    assign m0_gnt     = gnt_q[M_CPU];
    assign m1_gnt     = gnt_q[M_DMA];
    assign m0_ack     = ack_q[M_CPU];
    assign m1_ack     = ack_q[M_DMA];
    assign m0_rdata   = rdata_q[M_CPU];
    assign m1_rdata   = rdata_q[M_DMA];
    assign addressBus = addr_q;
    assign writeEnBus = we_q;
    assign data_c2r   = wd_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a WAIT_STATES=1 instance with a registered-read memory,
// plus WAIT_STATES=0 (combinational memory) and WAIT_STATES=7 instances for latency.
module tb_bus_arbiter;

    localparam int WS = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [15:0] addressBus;
    logic        writeEnBus;
    logic [7:0]  data_c2r, data_r2c;

    logic        s0_req, s7_req;
    logic [15:0] s_addr;
    logic [15:0] a0_bus, a7_bus;
    logic        z_we0, z_we7;
    logic [7:0]  z_c2r0, z_c2r7, r2c0, r2c7;
    logic        g0_m0, g0_m1, k0_m0, k0_m1, g7_m0, g7_m1, k7_m0, k7_m1;
    logic [7:0]  d0_m0, d0_m1, d7_m0, d7_m1;

    logic [1:0]      ack_v;
    logic [1:0][7:0] rd_v;
    assign ack_v = {m1_ack, m0_ack};
    assign rd_v  = {m1_rdata, m0_rdata};

    // Slave memory: 8-bit decode, registered read for the WS=1 and WS=7 buses.
    logic [7:0] mem [256];
    logic [7:0] rd_q, rd7_q;
    logic       pl_we;
    logic [7:0] pl_addr, pl_data;
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (writeEnBus) mem[addressBus[7:0]] <= data_c2r;
        rd_q  <= mem[addressBus[7:0]];
        rd7_q <= mem[a7_bus[7:0]];
    end
    assign data_r2c = rd_q;
    assign r2c7     = rd7_q;
    assign r2c0     = mem[a0_bus[7:0]];

    bus_arbiter #(.WAIT_STATES(WS), .ADDR_W(16), .DATA_W(8)) u_dut (
        .clock(clk), .reset(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .addressBus(addressBus), .writeEnBus(writeEnBus), .data_c2r(data_c2r),
        .data_r2c(data_r2c)
    );

    bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(8)) u_dut_ws0 (
        .clock(clk), .reset(rst_n),
        .m0_req(s0_req), .m1_req(1'b0), .m0_lock(1'b0), .m1_lock(1'b0),
        .m0_we(1'b0), .m1_we(1'b0), .m0_addr(s_addr), .m1_addr(16'h0000),
        .m0_wdata(8'h00), .m1_wdata(8'h00),
        .m0_gnt(g0_m0), .m1_gnt(g0_m1), .m0_ack(k0_m0), .m1_ack(k0_m1),
        .m0_rdata(d0_m0), .m1_rdata(d0_m1),
        .addressBus(a0_bus), .writeEnBus(z_we0), .data_c2r(z_c2r0),
        .data_r2c(r2c0)
    );

    bus_arbiter #(.WAIT_STATES(7), .ADDR_W(16), .DATA_W(8)) u_dut_ws7 (
        .clock(clk), .reset(rst_n),
        .m0_req(s7_req), .m1_req(1'b0), .m0_lock(1'b0), .m1_lock(1'b0),
        .m0_we(1'b0), .m1_we(1'b0), .m0_addr(s_addr), .m1_addr(16'h0000),
        .m0_wdata(8'h00), .m1_wdata(8'h00),
        .m0_gnt(g7_m0), .m1_gnt(g7_m1), .m0_ack(k7_m0), .m1_ack(k7_m1),
        .m0_rdata(d7_m0), .m1_rdata(d7_m1),
        .addressBus(a7_bus), .writeEnBus(z_we7), .data_c2r(z_c2r7),
        .data_r2c(r2c7)
    );

    // Reference model state
    int       n_checks = 0;
    int       n_fail   = 0;
    int       last_m   = 1;
    bit [7:0] exp_mem [256];
    bit       known   [256];

    function automatic int predict(input bit [1:0] r, input bit [1:0] l, input int last);
        if (r[last] && l[last]) return last;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return 1 - last;
    endfunction

    task automatic drive(input int m, input bit r, input bit l, input bit we,
                         input logic [15:0] a, input logic [7:0] d);
        if (m == 0) begin
            m0_req = r; m0_lock = l; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_lock = l; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a[7:0]; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
        exp_mem[a[7:0]] = d;
        known[a[7:0]]   = 1'b1;
    endtask

    // Single transaction driver; lat counts falling edges from the request until ack.
    task automatic txn(input int m, input bit we, input logic [15:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output int wep, output logic [7:0] c2r);
        @(negedge clk);
        drive(m, 1'b1, 1'b0, we, a, d);
        lat = 0; rd = 8'h00; wep = 0; c2r = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (writeEnBus) begin wep++; c2r = data_c2r; end
            if (ack_v[m]) begin rd = rd_v[m]; break; end
        end
        drive(m, 1'b0, 1'b0, 1'b0, a, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 0, 0, 16'h0, 8'h0);
        s0_req = 1'b0; s7_req = 1'b0; s_addr = 16'h0; pl_we = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m1_gnt, m0_gnt, m1_ack, m0_ack, writeEnBus} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {m1_gnt, m0_gnt, m1_ack, m0_ack, writeEnBus});
        end
        n_checks++;
        if (addressBus !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0000", addressBus); end
        n_checks++;
        if (data_c2r !== 8'h0) begin n_fail++; $display("FAIL reset_c2r got %h want 00", data_c2r); end
        n_checks++;
        if ({m1_rdata, m0_rdata} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", {m1_rdata, m0_rdata}); end
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = 1;
    endtask

    task automatic test_single_read();
        int k;
        preload(16'h0010, 8'h5A);
        @(negedge clk);
        drive(0, 1, 0, 0, 16'h0010, 8'h00);
        @(negedge clk);
        n_checks++;
        if (addressBus !== 16'h0010 || writeEnBus !== 1'b0 || m0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL read_bus got addr=%h we=%b gnt=%b want 0010 0 1", addressBus, writeEnBus, m0_gnt);
        end
        k = 1;
        while (!m0_ack && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (k != WS + 2) begin n_fail++; $display("FAIL read_latency got %0d want %0d", k, WS + 2); end
        n_checks++;
        if (m0_rdata !== exp_mem[8'h10]) begin n_fail++; $display("FAIL read_data got %h want %h", m0_rdata, exp_mem[8'h10]); end
        n_checks++;
        if ({m1_gnt, m1_ack, m1_rdata} !== 10'h0) begin n_fail++; $display("FAIL read_m1_quiet got %h want 0", {m1_gnt, m1_ack, m1_rdata}); end
        drive(0, 0, 0, 0, 16'h0010, 8'h00);
        last_m = predict(2'b01, 2'b00, last_m);
        @(negedge clk);
        n_checks++;
        if (m0_ack !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL ack_pulse got ack=%b gnt=%b want 0 0", m0_ack, m0_gnt); end
    endtask

    task automatic test_write_strobe();
        int lat, wep;
        logic [7:0] rd, c2r;
        txn(1, 1'b1, 16'h0020, 8'hC3, lat, rd, wep, c2r);
        last_m = predict(2'b10, 2'b00, last_m);
        exp_mem[8'h20] = 8'hC3; known[8'h20] = 1'b1;
        n_checks++;
        if (wep != 1) begin n_fail++; $display("FAIL write_strobe_len got %0d want 1", wep); end
        n_checks++;
        if (c2r !== 8'hC3) begin n_fail++; $display("FAIL write_data got %h want c3", c2r); end
        n_checks++;
        if (lat != WS + 2) begin n_fail++; $display("FAIL write_latency got %0d want %0d", lat, WS + 2); end
        txn(0, 1'b0, 16'h0020, 8'h00, lat, rd, wep, c2r);
        last_m = predict(2'b01, 2'b00, last_m);
        n_checks++;
        if (rd !== exp_mem[8'h20]) begin n_fail++; $display("FAIL readback got %h want %h", rd, exp_mem[8'h20]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [2];
        logic [1:0]  g, prev_g;
        int grants, prev_cyc, exp_w, obs_w;
        for (int m = 0; m < 2; m++) begin
            a[m] = 16'($urandom);
            preload(a[m], 8'($urandom));
        end
        grants = 0; prev_cyc = -1; prev_g = 2'b00;
        @(negedge clk);
        drive(0, 1, 0, 0, a[0], 8'h00);
        drive(1, 1, 0, 0, a[1], 8'h00);
        for (int cyc = 1; cyc < 80; cyc++) begin
            @(negedge clk);
            g = {m1_gnt, m0_gnt};
            n_checks++;
            if (g === 2'b11) begin n_fail++; $display("FAIL gnt_onehot got %b want not 11", g); end
            if (g != 2'b00 && prev_g == 2'b00) begin
                exp_w = predict(2'b11, 2'b00, last_m);
                obs_w = m1_gnt ? 1 : 0;
                n_checks++;
                if (obs_w != exp_w) begin n_fail++; $display("FAIL b2b_winner got m%0d want m%0d", obs_w, exp_w); end
                last_m = exp_w;
                grants++;
                if (prev_cyc >= 0) begin
                    n_checks++;
                    if (cyc - prev_cyc != WS + 3) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", cyc - prev_cyc, WS + 3); end
                end
                prev_cyc = cyc;
            end
            for (int m = 0; m < 2; m++) begin
                if (ack_v[m]) begin
                    n_checks++;
                    if (rd_v[m] !== exp_mem[a[m][7:0]]) begin n_fail++; $display("FAIL b2b_rdata m%0d got %h want %h", m, rd_v[m], exp_mem[a[m][7:0]]); end
                end
            end
            prev_g = g;
            if (ack_v != 2'b00 && grants == 4) break;
        end
        drive(0, 0, 0, 0, a[0], 8'h00);
        drive(1, 0, 0, 0, a[1], 8'h00);
        n_checks++;
        if (grants != 4) begin n_fail++; $display("FAIL b2b_grants got %0d want 4", grants); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock();
        logic [15:0] a0, a1;
        logic [1:0]  g, prev_g;
        logic [3:0]  pat;
        int n, m0_done, exp_w, obs_w;
        a0 = 16'($urandom); a1 = 16'($urandom);
        preload(a0, 8'($urandom));
        preload(a1, 8'($urandom));
        n = 0; m0_done = 0; pat = 4'b0; prev_g = 2'b00;
        @(negedge clk);
        drive(0, 1, 1, 0, a0, 8'h00);
        drive(1, 1, 0, 0, a1, 8'h00);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            g = {m1_gnt, m0_gnt};
            if (g != 2'b00 && prev_g == 2'b00) begin
                exp_w = predict({m1_req, m0_req}, {m1_lock, m0_lock}, last_m);
                obs_w = m1_gnt ? 1 : 0;
                n_checks++;
                if (obs_w != exp_w) begin n_fail++; $display("FAIL lock_winner got m%0d want m%0d", obs_w, exp_w); end
                last_m = exp_w;
                if (n < 4) pat[n] = obs_w[0];
                n++;
            end
            prev_g = g;
            if (m0_ack) begin
                m0_done++;
                if (m0_done == 3) m0_lock = 1'b0;
            end
            if (m1_ack) break;
        end
        drive(0, 0, 0, 0, a0, 8'h00);
        drive(1, 0, 0, 0, a1, 8'h00);
        n_checks++;
        if (n != 4 || pat !== 4'b1000) begin n_fail++; $display("FAIL lock_sequence got n=%0d pat=%b want 4 1000", n, pat); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] a;
        int acks, exp_w, obs_w, k;
        a = 16'($urandom);
        @(negedge clk);
        drive(0, 1, 0, 1, a, 8'($urandom));
        @(negedge clk);
        n_checks++;
        if (writeEnBus !== 1'b1) begin n_fail++; $display("FAIL mid_we_before got %b want 1", writeEnBus); end
        #2 rst_n = 1'b0;
        drive(0, 0, 0, 0, a, 8'h00);
        #1;
        n_checks++;
        if (writeEnBus !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_async got we=%b gnt=%b want 0 0", writeEnBus, m0_gnt); end
        known[a[7:0]] = 1'b0;
        last_m = 1;
        acks = 0;
        repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL mid_no_ack got %0d want 0", acks); end
        preload(16'h0044, 8'($urandom));
        @(negedge clk);
        drive(0, 1, 0, 0, 16'h0044, 8'h00);
        drive(1, 1, 0, 0, 16'h0044, 8'h00);
        k = 0;
        while (!(m0_gnt || m1_gnt) && k < 20) begin @(negedge clk); k++; end
        exp_w = predict(2'b11, 2'b00, last_m);
        obs_w = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
        n_checks++;
        if (obs_w != exp_w) begin n_fail++; $display("FAIL post_reset_tie got m%0d want m%0d", obs_w, exp_w); end
        last_m = exp_w;
        k = 0;
        while (!ack_v[exp_w] && k < 20) begin @(negedge clk); k++; end
        drive(0, 0, 0, 0, 16'h0, 8'h00);
        drive(1, 0, 0, 0, 16'h0, 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            logic [1:0]  rq, lk, wv, pend, g, prev_g;
            logic [15:0] a [2];
            logic [7:0]  d [2];
            int gcyc [2];
            int cyc, exp_w, obs_w;
            rq = 2'($urandom_range(1, 3));
            lk = 2'($urandom);
            wv = 2'($urandom);
            for (int m = 0; m < 2; m++) begin
                a[m] = 16'($urandom);
                d[m] = 8'($urandom);
                gcyc[m] = 0;
                if (rq[m] && !wv[m] && !known[a[m][7:0]]) preload(a[m], 8'($urandom));
            end
            @(negedge clk);
            for (int m = 0; m < 2; m++) if (rq[m]) drive(m, 1, lk[m], wv[m], a[m], d[m]);
            pend = rq; prev_g = 2'b00; cyc = 0;
            while (pend != 2'b00 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                g = {m1_gnt, m0_gnt};
                if (g != 2'b00 && prev_g == 2'b00) begin
                    exp_w = predict({m1_req, m0_req}, {m1_lock, m0_lock}, last_m);
                    obs_w = m1_gnt ? 1 : 0;
                    n_checks++;
                    if (obs_w != exp_w) begin n_fail++; $display("FAIL rnd_winner round %0d got m%0d want m%0d", r, obs_w, exp_w); end
                    last_m = exp_w;
                    gcyc[obs_w] = cyc;
                end
                for (int m = 0; m < 2; m++) begin
                    if (ack_v[m] && pend[m]) begin
                        n_checks++;
                        if (cyc - gcyc[m] != WS + 1) begin n_fail++; $display("FAIL rnd_latency m%0d got %0d want %0d", m, cyc - gcyc[m], WS + 1); end
                        if (!wv[m]) begin
                            n_checks++;
                            if (rd_v[m] !== exp_mem[a[m][7:0]]) begin n_fail++; $display("FAIL rnd_rdata m%0d got %h want %h", m, rd_v[m], exp_mem[a[m][7:0]]); end
                        end else begin
                            exp_mem[a[m][7:0]] = d[m];
                            known[a[m][7:0]]   = 1'b1;
                        end
                        pend[m] = 1'b0;
                        drive(m, 0, 0, 0, a[m], d[m]);
                    end
                end
                prev_g = g;
            end
            n_checks++;
            if (pend != 2'b00) begin n_fail++; $display("FAIL rnd_timeout round %0d pending %b want 00", r, pend); end
        end
    endtask

    task automatic test_wait_states();
        int k;
        preload(16'h0033, 8'($urandom));
        @(negedge clk);
        s_addr = 16'h0033; s0_req = 1'b1;
        k = 0;
        while (!k0_m0 && k < 30) begin @(negedge clk); k++; end
        s0_req = 1'b0;
        n_checks++;
        if (k != 2) begin n_fail++; $display("FAIL ws0_latency got %0d want 2", k); end
        n_checks++;
        if (d0_m0 !== exp_mem[8'h33]) begin n_fail++; $display("FAIL ws0_rdata got %h want %h", d0_m0, exp_mem[8'h33]); end
        preload(16'h0077, 8'($urandom));
        @(negedge clk);
        s_addr = 16'h0077; s7_req = 1'b1;
        k = 0;
        while (!k7_m0 && k < 30) begin @(negedge clk); k++; end
        s7_req = 1'b0;
        n_checks++;
        if (k != 9) begin n_fail++; $display("FAIL ws7_latency got %0d want 9", k); end
        n_checks++;
        if (d7_m0 !== exp_mem[8'h77]) begin n_fail++; $display("FAIL ws7_rdata got %h want %h", d7_m0, exp_mem[8'h77]); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin exp_mem[i] = 8'h00; known[i] = 1'b0; end
        test_reset();
        test_single_read();
        test_write_strobe();
        test_back_to_back();
        test_lock();
        test_reset_mid_access();
        test_random();
        test_wait_states();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
